// File: rtl/apb_mig_chk_pkg.sv
// Shared types for the APB-to-MIG bridge checker: error bit indices and APB phase states.
package apb_mig_chk_pkg;

    localparam int NUM_ERR = 5;

    typedef enum logic [2:0] {
        FIFO_STRAY  = 3'd0,
        FIFO_OVF    = 3'd1,
        PROTOCOL    = 3'd2,
        TIMEOUT     = 3'd3,
        OUTSTANDING = 3'd4
    } err_idx_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

endpackage

// File: rtl/apb_phase_tracker.sv
// APB phase FSM plus pready watchdog; emits single-cycle protocol and timeout error pulses.
module apb_phase_tracker
    import apb_mig_chk_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       psel,
    input  logic       penable,
    input  logic       pready,
    output apb_state_e state,
    output logic       access,
    output logic       protocol_err,
    output logic       timeout_err
);

    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYCLES);

    apb_state_e      state_q, state_d;
    logic            ready_q;
    logic [WD_W-1:0] wd_q, wd_d;
    logic            fired_q, fired_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ready_q <= 1'b0;
            wd_q    <= '0;
            fired_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ready_q <= pready;
            wd_q    <= wd_d;
            fired_q <= fired_d;
        end
    end

    // The watchdog saturates; fired_q keeps a long stall from reporting more than once.
    always_comb begin
        state_d      = IDLE;
        wd_d         = '0;
        fired_d      = 1'b0;
        access       = psel && penable;
        protocol_err = 1'b0;
        timeout_err  = 1'b0;

        if (psel && !penable) begin
            state_d = SETUP;
        end else if (access) begin
            state_d = ACCESS;
        end

        protocol_err = (penable && !psel)
                    || (access && state_q == IDLE)
                    || (state_q == SETUP && !access)
                    || (state_q == ACCESS && !ready_q && !access);

        timeout_err = (wd_q == WD_MAX) && !fired_q;

        if (access && !pready) begin
            wd_d    = (wd_q == WD_MAX) ? wd_q : wd_q + 1'b1;
            fired_d = fired_q || timeout_err;
        end
    end

    assign state = state_q;

endmodule

// File: rtl/apb_mig_checker.sv
// Protocol/health checker for the APB-to-MIG bridge: sticky error flags, event counter, outstanding reads.
// Define APB_MIG_CHK_SVA_EN to add one concurrent assertion per error condition.
module apb_mig_checker
    import apb_mig_chk_pkg::*;
#(
    parameter  int MAX_OUTSTANDING = 4,
    parameter  int TIMEOUT_CYCLES  = 256,
    parameter  int CNT_W           = 8,
    localparam int OUT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic               pclk_i,
    input  logic               preset_ni,
    input  logic               psel_i,
    input  logic               penable_i,
    input  logic               pwrite_i,
    input  logic               pready_i,
    input  logic               mig_req_valid_i,
    input  logic               mig_req_ready_i,
    input  logic               mig_rsp_valid_i,
    input  logic               fifo_w_full_i,
    input  logic               fifo_r_empty_i,
    input  logic               clear_i,
    output logic [NUM_ERR-1:0] err_o,
    output logic [CNT_W-1:0]   err_cnt_o,
    output logic [OUT_W-1:0]   outstanding_o,
    output logic               busy_o
);

    localparam logic [OUT_W-1:0] OUT_MAX = OUT_W'(MAX_OUTSTANDING);

    apb_state_e         phase;
    logic               access;
    logic               protocol_err;
    logic               timeout_err;
    logic               req_fire;
    logic               out_err;
    logic               any_err;
    logic [OUT_W-1:0]   out_q, out_d;
    logic [NUM_ERR-1:0] err_now, err_q;
    logic [CNT_W-1:0]   cnt_q;

    apb_phase_tracker #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_tracker (
        .clk          (pclk_i),
        .rst_n        (preset_ni),
        .psel         (psel_i),
        .penable      (penable_i),
        .pready       (pready_i),
        .state        (phase),
        .access       (access),
        .protocol_err (protocol_err),
        .timeout_err  (timeout_err)
    );

    // A request and a response in the same cycle cancel, so only unpaired events can over/underflow.
    always_comb begin
        req_fire = mig_req_valid_i && mig_req_ready_i;
        out_d    = out_q;
        out_err  = 1'b0;
        if (req_fire && !mig_rsp_valid_i) begin
            if (out_q == OUT_MAX) out_err = 1'b1;
            else                  out_d   = out_q + 1'b1;
        end else if (mig_rsp_valid_i && !req_fire) begin
            if (out_q == '0) out_err = 1'b1;
            else             out_d   = out_q - 1'b1;
        end
    end

    always_comb begin
        err_now              = '0;
        err_now[FIFO_STRAY]  = !fifo_r_empty_i && !(access && !pwrite_i);
        err_now[FIFO_OVF]    = mig_rsp_valid_i && fifo_w_full_i;
        err_now[PROTOCOL]    = protocol_err;
        err_now[TIMEOUT]     = timeout_err;
        err_now[OUTSTANDING] = out_err;
        any_err              = |err_now;
    end

    // Clear wins over the held flags but never hides an error raised in the same cycle.
    always_ff @(posedge pclk_i or negedge preset_ni) begin
        if (!preset_ni) begin
            out_q <= '0;
            err_q <= '0;
            cnt_q <= '0;
        end else begin
            out_q <= out_d;
            if (clear_i) begin
                err_q <= err_now;
                cnt_q <= CNT_W'(any_err);
            end else begin
                err_q <= err_q | err_now;
                if (any_err && cnt_q != '1) cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign err_o         = err_q;
    assign err_cnt_o     = cnt_q;
    assign outstanding_o = out_q;
    assign busy_o        = (phase != IDLE) || (out_q != '0);

`ifdef APB_MIG_CHK_SVA_EN
    a_fifo_stray: assert property (@(posedge pclk_i) disable iff (!preset_ni) !err_now[FIFO_STRAY])
        else $error("apb_mig_checker: mig2apb FIFO holds data outside an APB read access");
    a_fifo_ovf: assert property (@(posedge pclk_i) disable iff (!preset_ni) !err_now[FIFO_OVF])
        else $error("apb_mig_checker: MIG response written into a full mig2apb FIFO");
    a_protocol: assert property (@(posedge pclk_i) disable iff (!preset_ni) !err_now[PROTOCOL])
        else $error("apb_mig_checker: illegal APB psel/penable sequence");
    a_timeout: assert property (@(posedge pclk_i) disable iff (!preset_ni) !err_now[TIMEOUT])
        else $error("apb_mig_checker: pready watchdog expired");
    a_outstanding: assert property (@(posedge pclk_i) disable iff (!preset_ni) !err_now[OUTSTANDING])
        else $error("apb_mig_checker: MIG outstanding read count over/underflow");
`endif

endmodule

// File: tb/tb_apb_mig_checker.sv
// Self-checking bench for apb_mig_checker: directed scenarios plus randomized APB/MIG traffic vs a behavioural model.
module tb_apb_mig_checker;

    localparam int MAX_OUT = 2;
    localparam int TMO     = 8;
    localparam int CW      = 5;
    localparam int OUT_W   = $clog2(MAX_OUT + 1);
    localparam int CNT_MAX = (1 << CW) - 1;

    logic             pclk = 1'b0;
    logic             preset_n = 1'b0;
    logic             psel = 1'b0, penable = 1'b0, pwrite = 1'b0, pready = 1'b0;
    logic             req_valid = 1'b0, req_ready = 1'b0, rsp_valid = 1'b0;
    logic             w_full = 1'b0, r_empty = 1'b1, clear = 1'b0;
    logic [4:0]       err;
    logic [CW-1:0]    err_cnt;
    logic [OUT_W-1:0] outstanding;
    logic             busy;

    int checks_total  = 0;
    int checks_passed = 0;

    // Reference model state: phase 0/1/2 = idle/setup/access of the previous cycle.
    int     m_phase;
    int     m_stall;
    int     m_out;
    int     m_cnt;
    bit     m_prev_ready;
    bit [4:0] m_err;

    apb_mig_checker #(
        .MAX_OUTSTANDING(MAX_OUT),
        .TIMEOUT_CYCLES (TMO),
        .CNT_W          (CW)
    ) dut (
        .pclk_i          (pclk),
        .preset_ni       (preset_n),
        .psel_i          (psel),
        .penable_i       (penable),
        .pwrite_i        (pwrite),
        .pready_i        (pready),
        .mig_req_valid_i (req_valid),
        .mig_req_ready_i (req_ready),
        .mig_rsp_valid_i (rsp_valid),
        .fifo_w_full_i   (w_full),
        .fifo_r_empty_i  (r_empty),
        .clear_i         (clear),
        .err_o           (err),
        .err_cnt_o       (err_cnt),
        .outstanding_o   (outstanding),
        .busy_o          (busy)
    );

    always #5 pclk = ~pclk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks_total++;
        if (observed === expected) checks_passed++;
        else $display("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, observed, expected, $time);
    endtask

    task automatic modelReset();
        m_phase      = 0;
        m_stall      = 0;
        m_out        = 0;
        m_cnt        = 0;
        m_prev_ready = 1'b0;
        m_err        = '0;
    endtask

    // One clock edge worth of specification rules, evaluated on the inputs held during that cycle.
    task automatic modelStep();
        bit       sel_en, req, prot, tmo, stray, ovf, oerr;
        bit [4:0] fired;
        sel_en = psel && penable;
        req    = req_valid && req_ready;
        prot   = (penable && !psel) || (sel_en && m_phase == 0) || (m_phase == 1 && !sel_en)
              || (m_phase == 2 && !m_prev_ready && !sel_en);
        tmo    = (m_stall == TMO);
        stray  = !r_empty && !(sel_en && !pwrite);
        ovf    = rsp_valid && w_full;
        oerr   = 1'b0;
        if (req && !rsp_valid) begin
            if (m_out == MAX_OUT) oerr = 1'b1; else m_out++;
        end else if (rsp_valid && !req) begin
            if (m_out == 0) oerr = 1'b1; else m_out--;
        end
        fired = {oerr, tmo, prot, ovf, stray};
        if (clear) begin
            m_err = fired;
            m_cnt = (fired != 0) ? 1 : 0;
        end else begin
            m_err = m_err | fired;
            if (fired != 0 && m_cnt < CNT_MAX) m_cnt++;
        end
        m_stall      = (sel_en && !pready) ? m_stall + 1 : 0;
        m_prev_ready = pready;
        m_phase      = psel ? (penable ? 2 : 1) : 0;
    endtask

    task automatic compareAll(input string tag);
        checkOutput({tag, ".err"}, 32'(err), 32'(m_err));
        checkOutput({tag, ".err_cnt"}, 32'(err_cnt), 32'(m_cnt));
        checkOutput({tag, ".outstanding"}, 32'(outstanding), 32'(m_out));
        checkOutput({tag, ".busy"}, 32'(busy), 32'((m_phase != 0 || m_out != 0) ? 1 : 0));
    endtask

    task automatic applyStimulus(input logic s, input logic e, input logic w, input logic r,
                                 input logic qv, input logic qr, input logic rv,
                                 input logic wf, input logic re, input logic cl);
        @(negedge pclk);
        psel = s; penable = e; pwrite = w; pready = r;
        req_valid = qv; req_ready = qr; rsp_valid = rv;
        w_full = wf; r_empty = re; clear = cl;
        @(posedge pclk);
        #1;
        modelStep();
        compareAll("cycle");
    endtask

    task automatic idleCycle(input logic cl);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, cl);
    endtask

    function automatic logic rbit(input int pct);
        return ($urandom_range(0, 99) < pct) ? 1'b1 : 1'b0;
    endfunction

    task automatic randStep(input logic s, input logic e, input logic w, input logic r);
        applyStimulus(s, e, w, r, rbit(50), rbit(50), rbit(35), rbit(15), rbit(85), rbit(6));
    endtask

    initial begin
        int first_tmo;
        int waits;
        int mode;
        logic dir;

        modelReset();
        #1;
        compareAll("reset");
        @(negedge pclk);
        @(negedge pclk);
        preset_n = 1'b1;

        // Legal write, then back-to-back read with two wait states each.
        applyStimulus(1, 0, 1, 0, 0, 0, 0, 0, 1, 0);
        applyStimulus(1, 1, 1, 0, 0, 0, 0, 0, 1, 0);
        applyStimulus(1, 1, 1, 0, 0, 0, 0, 0, 1, 0);
        applyStimulus(1, 1, 1, 1, 0, 0, 0, 0, 1, 0);
        applyStimulus(1, 0, 0, 0, 1, 1, 0, 0, 1, 0);
        applyStimulus(1, 1, 0, 0, 0, 0, 1, 0, 1, 0);
        applyStimulus(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 1, 0, 1, 0, 0, 0, 0, 0, 0);
        idleCycle(0);
        checkOutput("legal.err", 32'(err), 32'd0);
        checkOutput("legal.err_cnt", 32'(err_cnt), 32'd0);
        checkOutput("legal.busy", 32'(busy), 32'd0);

        // Access without setup, then clear.
        applyStimulus(1, 1, 0, 1, 0, 0, 0, 0, 1, 0);
        checkOutput("skip_setup.err2", 32'(err[2]), 32'd1);
        checkOutput("skip_setup.err_cnt", 32'(err_cnt), 32'd1);
        idleCycle(1);
        checkOutput("clear.err", 32'(err), 32'd0);
        checkOutput("clear.err_cnt", 32'(err_cnt), 32'd0);

        // Watchdog: 12 stalled access cycles, flag must rise 9 cycles after access start.
        first_tmo = 0;
        applyStimulus(1, 0, 1, 0, 0, 0, 0, 0, 1, 0);
        for (int k = 1; k <= 12; k++) begin
            applyStimulus(1, 1, 1, 0, 0, 0, 0, 0, 1, 0);
            if (err[3] && first_tmo == 0) first_tmo = k;
        end
        applyStimulus(1, 1, 1, 1, 0, 0, 0, 0, 1, 0);
        idleCycle(0);
        checkOutput("timeout.rise_cycle", 32'(first_tmo), 32'd9);
        checkOutput("timeout.err_cnt", 32'(err_cnt), 32'd1);
        checkOutput("timeout.err", 32'(err), 32'h08);
        idleCycle(1);

        // Outstanding counter limits.
        repeat (3) applyStimulus(0, 0, 0, 0, 1, 1, 0, 0, 1, 0);
        checkOutput("outst.count_max", 32'(outstanding), 32'd2);
        checkOutput("outst.over_err", 32'(err[4]), 32'd1);
        applyStimulus(0, 0, 0, 0, 1, 1, 1, 0, 1, 0);
        checkOutput("outst.paired", 32'(outstanding), 32'd2);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 1, 1);
        checkOutput("outst.cleared_err4", 32'(err[4]), 32'd0);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 1, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 1, 0);
        checkOutput("outst.under_count", 32'(outstanding), 32'd0);
        checkOutput("outst.under_err", 32'(err[4]), 32'd1);
        idleCycle(1);

        // FIFO stray data during a write access, then a response into a full FIFO.
        applyStimulus(1, 0, 1, 0, 0, 0, 0, 0, 1, 0);
        applyStimulus(1, 1, 1, 1, 0, 0, 0, 0, 0, 0);
        checkOutput("fifo.stray", 32'(err[0]), 32'd1);
        applyStimulus(0, 0, 0, 0, 1, 1, 1, 1, 1, 0);
        checkOutput("fifo.ovf", 32'(err[1]), 32'd1);

        // Asynchronous reset in the middle of a stalled access with flags set.
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        @(negedge pclk);
        psel = 1; penable = 1; pwrite = 0; pready = 0; r_empty = 1;
        #2 preset_n = 1'b0;
        #1;
        modelReset();
        checkOutput("rst_mid.err", 32'(err), 32'd0);
        checkOutput("rst_mid.err_cnt", 32'(err_cnt), 32'd0);
        checkOutput("rst_mid.outstanding", 32'(outstanding), 32'd0);
        checkOutput("rst_mid.busy", 32'(busy), 32'd0);
        @(negedge pclk);
        psel = 0; penable = 0;
        @(negedge pclk);
        preset_n = 1'b1;
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        applyStimulus(1, 1, 0, 1, 0, 0, 0, 0, 1, 0);
        idleCycle(0);
        checkOutput("post_rst.err", 32'(err), 32'd0);
        checkOutput("post_rst.err_cnt", 32'(err_cnt), 32'd0);

        // Mostly-legal randomized transfers with occasional skipped setup or dropped access.
        for (int t = 0; t < 60; t++) begin
            waits = $urandom_range(0, 11);
            mode  = $urandom_range(0, 9);
            dir   = rbit(50);
            if (mode != 0) randStep(1, 0, dir, 0);
            for (int k = 0; k < waits; k++) randStep(1, 1, dir, 0);
            if (mode == 1) randStep(0, 0, 0, 0);
            else           randStep(1, 1, dir, 1);
            if (rbit(50)) randStep(0, 0, 0, 0);
        end

        // Unconstrained random cycles to hit protocol corner cases and counter saturation.
        for (int t = 0; t < 250; t++) begin
            randStep(rbit(60), rbit(50), rbit(50), rbit(40));
        end

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule

// File: doc/apb_mig_checker.md
Name: apb_mig_checker

Overview:
- Synthesizable, parametrised protocol/health checker for the APB-to-MIG bridge.
- Sits alongside the bridge in the APB clock domain and snoops the APB slave signals, MIG request/response handshakes and the mig2apb FIFO status flags.
- Tracks the APB phase with an FSM, counts outstanding MIG reads and runs a pready watchdog.
- Reports violations as sticky, software-clearable error flags plus a saturating event counter, usable in silicon and in simulation.

Parameters:
- MAX_OUTSTANDING, 4: max MIG read requests in flight before a request is illegal.
- TIMEOUT_CYCLES, 256: access-phase cycles without pready before a timeout error; must be >= 1.
- CNT_W, 8: width of the error event counter.

Ports:
- pclk_i  in  1  APB clock; the only clock.
- preset_ni  in  1  asynchronous active-low reset.
- psel_i  in  1  APB select (snooped).
- penable_i  in  1  APB enable (snooped).
- pwrite_i  in  1  APB direction, 1 = write (snooped).
- pready_i  in  1  APB ready from the bridge (snooped).
- mig_req_valid_i  in  1  bridge issues a MIG read request.
- mig_req_ready_i  in  1  MIG accepts the request.
- mig_rsp_valid_i  in  1  MIG read data valid (MIG writes it into the FIFO).
- fifo_w_full_i  in  1  mig2apb FIFO write-side full.
- fifo_r_empty_i  in  1  mig2apb FIFO read-side empty.
- clear_i  in  1  synchronous clear of the sticky flags and the event counter.
- err_o  out  5  sticky error flags; the bit index is given by err_idx_e.
- err_cnt_o  out  CNT_W  saturating count of cycles in which at least one error fired.
- outstanding_o  out  $clog2(MAX_OUTSTANDING+1)  current number of in-flight MIG reads.
- busy_o  out  1  FSM is not IDLE, or outstanding_o != 0.

Behaviour:
- Reset: all outputs are 0 and the FSM is IDLE. Reset is asynchronous and applies immediately, including mid-transfer.
- Latency: an error detected in cycle N appears on err_o and err_cnt_o in cycle N+1.
- FSM (registered phase of the previous cycle): IDLE, SETUP, ACCESS.
  - Next state: psel&&!penable -> SETUP; psel&&penable -> ACCESS; otherwise IDLE.
  - In ACCESS with pready_i=1, the transfer completes and the next state follows the same rule, so back-to-back SETUP is legal.
- ERR_PROTOCOL (bit 2) fires on any of:
  - penable without psel;
  - psel&&penable while the previous state was IDLE (setup phase skipped);
  - previous state SETUP and the current cycle is not psel&&penable;
  - previous state ACCESS without pready and the current cycle is not psel&&penable (transfer dropped).
- ERR_FIFO_STRAY (bit 0): !fifo_r_empty_i while not (psel&&penable&&!pwrite).
- ERR_FIFO_OVF (bit 1): mig_rsp_valid_i && fifo_w_full_i.
- ERR_TIMEOUT (bit 3):
  - The watchdog increments each access cycle with pready_i=0.
  - It clears on pready_i or on leaving ACCESS.
  - It saturates at TIMEOUT_CYCLES and fires once per transfer, on the cycle the count reaches TIMEOUT_CYCLES.
- Outstanding counter:
  - +1 on mig_req_valid_i&&mig_req_ready_i; -1 on mig_rsp_valid_i; both in the same cycle -> unchanged.
  - A request accepted at MAX_OUTSTANDING, or a response while the count is 0, fires ERR_OUTSTANDING (bit 4) and holds the count; no wrap.
- Sticky flags: err_o[i] stays set until clear_i. If clear_i and a new error coincide, the new error's bit is set and the counter becomes 1.
- err_cnt_o saturates at all-ones and never wraps.

Optional Feature:
- APB_MIG_CHK_SVA_EN defined:
  - adds one concurrent assertion per error condition, each with its own $error message;
  - assertions are clocked on pclk_i, use disable iff (!preset_ni), and fire in the violating cycle.
- Undefined: flags and counter only, no assertion code.
- Flag and counter behaviour is identical either way.

Decomposition:
- Package apb_mig_chk_pkg:
  - err_idx_e enum: FIFO_STRAY=0, FIFO_OVF=1, PROTOCOL=2, TIMEOUT=3, OUTSTANDING=4;
  - NUM_ERR=5;
  - apb_state_e enum: IDLE, SETUP, ACCESS.
- Sub-module apb_phase_tracker: the FSM plus the watchdog. It outputs the protocol and timeout error pulses and the access-phase indication.
- The top level holds the outstanding counter, the FIFO checks, the sticky flags and the event counter.

Test Plan:
- Legal write then back-to-back read, pready after 2 wait states -> err_o=0, err_cnt_o=0, busy_o=0 after completion.
- psel=1,penable=1 directly from idle -> err_o[2]=1 next cycle and err_cnt_o=1. clear_i pulse -> err_o=0, err_cnt_o=0.
- TIMEOUT_CYCLES=8, access held with pready=0 for 12 cycles -> err_o[3] rises exactly 9 cycles after access start; err_cnt_o=1 (single fire).
- MAX_OUTSTANDING=2: three accepted requests with no responses -> outstanding_o=2 and err_o[4]=1. Then response+request in the same cycle -> outstanding_o stays 2. Response with count 0 -> err_o[4] set again.
- fifo_r_empty=0 during an APB write access -> err_o[0]=1. mig_rsp_valid with fifo_w_full=1 -> err_o[1]=1.
- Reset asserted mid-access with flags set -> all outputs 0 immediately; after release, a legal transfer produces no errors.
